// File: rtl/mod_addsub_ctrl.sv
// Modular add/subtract sequencer.
// Drives one shared (WIDTH+1)-bit adder through a primary operation and,
// when needed, a correction by M, so that the response is always < M.
module mod_addsub_ctrl #(
  parameter int unsigned WIDTH      = 514,
  parameter int unsigned CONST_TIME = 0
) (
  input  logic             clk,
  input  logic             rst,
  // request channel
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [WIDTH-1:0] req_m,
  // shared adder
  output logic             add_start,
  output logic             add_subtract,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH:0]   add_result,
  input  logic             add_done,
  // response channel
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE,
    S1_ISSUE,
    S1_WAIT,
    S2_ISSUE,
    S2_WAIT,
    RESP
  } state_e;

  localparam logic OP_ADD = 1'b0;

  state_e           state_q, state_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] r1_q, r1_d;
  // high when the second adder step is a real correction (not a discarded dummy)
  logic             fix_q, fix_d;

  logic             add_start_q, add_start_d;
  logic             add_sub_q, add_sub_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             busy_q, busy_d;

  // Ready only in IDLE; forced low while reset is held.
  assign req_ready = (state_q == IDLE) && !rst;

  // Next-state, datapath capture and registered-output decode.
  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    m_d         = m_q;
    r1_d        = r1_q;
    fix_d       = fix_q;
    add_start_d = 1'b0;
    add_sub_d   = add_sub_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          op_d        = req_op;
          m_d         = req_m;
          fix_d       = 1'b0;
          add_start_d = 1'b1;
          add_sub_d   = req_op;
          add_a_d     = req_a;
          add_b_d     = req_b;
          state_d     = S1_ISSUE;
        end
      end

      S1_ISSUE: begin
        state_d = S1_WAIT;
      end

      S1_WAIT: begin
        if (add_done) begin
          r1_d = add_result[WIDTH-1:0];
          if (op_q == OP_ADD) begin
            // trial subtraction of M; the borrow decides which value to keep
            add_start_d = 1'b1;
            add_sub_d   = 1'b1;
            add_a_d     = add_result[WIDTH-1:0];
            add_b_d     = m_q;
            fix_d       = 1'b1;
            state_d     = S2_ISSUE;
          end else if (add_result[WIDTH]) begin
            // negative difference: add M back
            add_start_d = 1'b1;
            add_sub_d   = 1'b0;
            add_a_d     = add_result[WIDTH-1:0];
            add_b_d     = m_q;
            fix_d       = 1'b1;
            state_d     = S2_ISSUE;
          end else if (CONST_TIME != 0) begin
            // dummy correction to equalise latency; its result is dropped
            add_start_d = 1'b1;
            add_sub_d   = 1'b0;
            add_a_d     = add_result[WIDTH-1:0];
            add_b_d     = m_q;
            fix_d       = 1'b0;
            state_d     = S2_ISSUE;
          end else begin
            rsp_data_d = add_result[WIDTH-1:0];
            state_d    = RESP;
          end
        end
      end

      S2_ISSUE: begin
        state_d = S2_WAIT;
      end

      S2_WAIT: begin
        if (add_done) begin
          if (op_q == OP_ADD) begin
            rsp_data_d = add_result[WIDTH] ? r1_q : add_result[WIDTH-1:0];
          end else begin
            rsp_data_d = fix_q ? add_result[WIDTH-1:0] : r1_q;
          end
          state_d = RESP;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    rsp_valid_d = (state_d == RESP);
    busy_d      = (state_d != IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      op_q        <= 1'b0;
      m_q         <= '0;
      r1_q        <= '0;
      fix_q       <= 1'b0;
      add_start_q <= 1'b0;
      add_sub_q   <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      m_q         <= m_d;
      r1_q        <= r1_d;
      fix_q       <= fix_d;
      add_start_q <= add_start_d;
      add_sub_q   <= add_sub_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      busy_q      <= busy_d;
    end
  end

  assign add_start    = add_start_q;
  assign add_subtract = add_sub_q;
  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_mod_addsub_ctrl.sv
// Bench for mod_addsub_ctrl: runs a CONST_TIME=0 and a CONST_TIME=1 instance
// side by side, each with its own behavioural adder, and checks every
// response and adder request against an arithmetic model of modular add/sub.
module tb_mod_addsub_ctrl;

  localparam int unsigned WIDTH = 514;
  typedef logic [WIDTH:0] val_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_op = 1'b0;
  logic [WIDTH-1:0] req_a = '0;
  logic [WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0] req_m = '0;
  logic             rsp_ready = 1'b1;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int stall_max = 0;
  int stall_fix = -1;
  int bp_mode = 0;

  logic [1:0] rdy_v, busy_v, start_v, rspv_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input int inst, input val_t got, input val_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s[%0d]: got %0h expected %0h", tag, inst, got, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    logic             req_ready, add_start, add_subtract, add_done, rsp_valid, busy;
    logic [WIDTH-1:0] add_a, add_b, rsp_data;
    logic [WIDTH:0]   add_result;
    logic [WIDTH:0]   res = '0;
    int               stall_left = 0;

    mod_addsub_ctrl #(.WIDTH(WIDTH), .CONST_TIME(g)) dut (
      .clk         (clk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_a       (req_a),
      .req_b       (req_b),
      .req_m       (req_m),
      .add_start   (add_start),
      .add_subtract(add_subtract),
      .add_a       (add_a),
      .add_b       (add_b),
      .add_result  (add_result),
      .add_done    (add_done),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .busy        (busy)
    );

    assign rdy_v[g]   = req_ready;
    assign busy_v[g]  = busy;
    assign start_v[g] = add_start;
    assign rspv_v[g]  = rsp_valid;

    // Adder model: registers operands on the start edge; result is garbage until done.
    always @(posedge clk) begin
      if (add_start) begin
        res <= add_subtract ? ({1'b0, add_a} - {1'b0, add_b}) : ({1'b0, add_a} + {1'b0, add_b});
        stall_left <= (stall_fix >= 0) ? stall_fix : int'($urandom_range(0, stall_max));
      end else if (stall_left > 0) begin
        stall_left <= stall_left - 1;
      end
    end
    assign add_done   = (stall_left == 0);
    assign add_result = add_done ? res : '1;

    // Monitor and reference model for this instance.
    logic [WIDTH-1:0] exp_r, held;
    logic [WIDTH-1:0] ea [2];
    logic [WIDTH-1:0] eb [2];
    logic             es [2];
    logic [WIDTH:0]   sum;
    int hs_cyc = 0, exp_lat = 0, exp_pls = 0, npls = 0;
    bit pend = 0, seen = 0, timed = 0;

    initial forever begin
      @(negedge clk);
      if (rst) begin
        pend = 0;
        seen = 0;
        npls = 0;
      end else begin
        if (add_start) begin
          check_val("start_pending", g, val_t'(pend), val_t'(1));
          if (npls < 2) begin
            check_val("pulse_a", g, val_t'(add_a), val_t'(ea[npls]));
            check_val("pulse_b", g, val_t'(add_b), val_t'(eb[npls]));
            check_val("pulse_sub", g, val_t'(add_subtract), val_t'(es[npls]));
          end
          npls++;
        end
        if (rsp_valid) begin
          if (!seen) begin
            check_val("rsp_pending", g, val_t'(pend), val_t'(1));
            check_val("rsp_data", g, val_t'(rsp_data), val_t'(exp_r));
            check_val("start_count", g, val_t'(npls), val_t'(exp_pls));
            if (timed) check_val("latency", g, val_t'(cyc - hs_cyc), val_t'(exp_lat));
            held = rsp_data;
            seen = 1;
          end else begin
            check_val("rsp_stable", g, val_t'(rsp_data), val_t'(held));
          end
          check_val("ready_in_resp", g, val_t'(req_ready), val_t'(0));
          if (rsp_ready) begin
            pend = 0;
            seen = 0;
          end
        end
        check_val("busy_vs_ready", g, val_t'(busy), val_t'(!req_ready));
        if (req_valid && req_ready) begin
          pend   = 1;
          seen   = 0;
          npls   = 0;
          hs_cyc = cyc;
          timed  = (stall_max == 0) && (stall_fix <= 0);
          ea[0]  = req_a;
          eb[0]  = req_b;
          es[0]  = req_op;
          eb[1]  = req_m;
          if (!req_op) begin
            sum     = {1'b0, req_a} + {1'b0, req_b};
            exp_r   = (sum >= {1'b0, req_m}) ? WIDTH'(sum - {1'b0, req_m}) : WIDTH'(sum);
            ea[1]   = WIDTH'(sum);
            es[1]   = 1'b1;
            exp_pls = 2;
            exp_lat = 5;
          end else begin
            exp_r = (req_a >= req_b) ? (req_a - req_b) : (req_a + req_m - req_b);
            ea[1] = req_a - req_b;
            es[1] = 1'b0;
            if (req_a < req_b || g == 1) begin
              exp_pls = 2;
              exp_lat = 5;
            end else begin
              exp_pls = 1;
              exp_lat = 3;
            end
          end
        end
      end
    end
  end

  // Response-side backpressure: 0 = always ready, 1 = random, 2 = held off.
  initial forever begin
    @(posedge clk);
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  function automatic logic [WIDTH-1:0] rand_wide(input int nb);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int i = 0; i < 17; i++) r = {r[WIDTH-33:0], 32'($urandom())};
    return r & ({WIDTH{1'b1}} >> (WIDTH - nb));
  endfunction

  task automatic wait_idle();
    int t = 0;
    @(posedge clk);
    #1;
    while (rdy_v != 2'b11 && t < 500) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t >= 500) check_val("idle_timeout", 0, val_t'(rdy_v), val_t'(3));
  endtask

  task automatic do_req(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] m);
    wait_idle();
    req_valid = 1'b1;
    req_op    = op;
    req_a     = a;
    req_b     = b;
    req_m     = m;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic run_txn(input logic op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] m);
    do_req(op, a, b, m);
    wait_idle();
  endtask

  logic [WIDTH-1:0] ra, rb, rm;
  logic [WIDTH-1:0] big;

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_ctl0", 0, val_t'({gi[0].req_ready, gi[0].busy, gi[0].rsp_valid, gi[0].add_start, gi[0].add_subtract}), val_t'(0));
    check_val("rst_dat0", 0, val_t'(gi[0].add_a | gi[0].add_b | gi[0].rsp_data), val_t'(0));
    check_val("rst_ctl1", 1, val_t'({gi[1].req_ready, gi[1].busy, gi[1].rsp_valid, gi[1].add_start, gi[1].add_subtract}), val_t'(0));
    check_val("rst_dat1", 1, val_t'(gi[1].add_a | gi[1].add_b | gi[1].rsp_data), val_t'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("post_rst_ready", 0, val_t'(rdy_v), val_t'(3));
    check_val("post_rst_busy", 0, val_t'({busy_v, rspv_v, start_v}), val_t'(0));

    // directed cases, M = 13
    run_txn(1'b0, 7, 9, 13);
    run_txn(1'b0, 5, 8, 13);
    run_txn(1'b0, 2, 3, 13);
    run_txn(1'b1, 9, 3, 13);
    run_txn(1'b1, 3, 9, 13);
    run_txn(1'b1, 5, 5, 13);
    run_txn(1'b0, 0, 0, 13);
    run_txn(1'b1, 0, 0, 13);
    big = {2'b01, {(WIDTH-2){1'b1}}};
    run_txn(1'b0, big - 1, big - 2, big);
    run_txn(1'b1, 0, big - 1, big);

    // response backpressure: hold rsp_ready low for 4 cycles
    bp_mode = 2;
    do_req(1'b0, 7, 9, 13);
    for (int t = 0; t < 50 && rspv_v != 2'b11; t++) @(negedge clk);
    check_val("rsp_arrived", 0, val_t'(rspv_v), val_t'(3));
    repeat (4) @(negedge clk);
    bp_mode = 0;
    wait_idle();

    // request while busy must not be accepted
    do_req(1'b0, 7, 9, 13);
    req_valid = 1'b1;
    req_a     = 1;
    req_b     = 2;
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      check_val("accept_while_busy", 0, val_t'(rdy_v & {2{req_valid}}), val_t'(0));
    end
    req_valid = 1'b0;
    wait_idle();

    // adder stall of 3 cycles after each start
    stall_fix = 3;
    run_txn(1'b0, 7, 9, 13);
    run_txn(1'b1, 3, 9, 13);
    stall_fix = -1;

    // reset while in S2_WAIT
    stall_fix = 6;
    do_req(1'b0, 7, 9, 13);
    begin
      int np = 0;
      for (int t = 0; t < 50 && np < 2; t++) begin
        @(negedge clk);
        if (start_v[0]) np++;
      end
      check_val("second_pulse_seen", 0, val_t'(np), val_t'(2));
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_val("abort_busy", 0, val_t'(busy_v), val_t'(0));
    check_val("abort_rsp", 0, val_t'(rspv_v), val_t'(0));
    check_val("abort_start", 0, val_t'(start_v), val_t'(0));
    stall_fix = -1;
    begin
      int nr = 0;
      for (int t = 0; t < 20; t++) begin
        @(negedge clk);
        if (rspv_v != 2'b00) nr++;
      end
      check_val("no_rsp_after_abort", 0, val_t'(nr), val_t'(0));
    end
    run_txn(1'b0, 7, 9, 13);

    // randomized: stalls and backpressure, then clean timing
    for (int n = 0; n < 200; n++) begin
      int nb, k;
      stall_max = (n < 150) ? 2 : 0;
      bp_mode   = (n < 150) ? 1 : 0;
      case ($urandom_range(0, 2))
        0:       nb = 8;
        1:       nb = 64;
        default: nb = WIDTH - 1;
      endcase
      rm = rand_wide(nb);
      if (rm < 2) rm = 2;
      ra = rand_wide(nb);
      while (ra >= rm) ra = ra >> 1;
      rb = rand_wide(nb);
      while (rb >= rm) rb = rb >> 1;
      k = int'($urandom_range(0, 5));
      if (k == 0) rb = ra;
      else if (k == 1) rb = (ra == 0) ? '0 : rm - ra;
      else if (k == 2) ra = '0;
      run_txn(1'($urandom_range(0, 1)), ra, rb, rm);
    end
    bp_mode   = 0;
    stall_max = 0;
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
